// File: rtl/wb_byte_mem_bridge.sv
// Wishbone classic 32-bit slave that serialises each word access into four
// big-endian byte accesses on a byte-wide memory with combinational read.
module wb_byte_mem_bridge #(
    parameter int ADR_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic [ADR_W-1:0] mem_adr,
    output logic [7:0]       mem_dat_o,
    input  logic [7:0]       mem_dat_i,
    output logic             mem_we,
    output logic             mem_en
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       idx;
    logic [ADR_W-3:0] base;
    logic [3:0]       sel;
    logic             we;
    logic [31:0]      wdata;
    logic [1:0]       lane;
    logic             accept;

    // Byte at base+idx carries lane 3-idx (big-endian).
    assign lane   = 2'd3 - idx;
    assign accept = (state == IDLE) && wb_cyc_i && wb_stb_i && !wb_ack_o;

    // State register, byte index and request capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            base  <= '0;
            sel   <= '0;
            we    <= 1'b0;
            wdata <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                idx   <= '0;
                base  <= wb_adr_i[ADR_W-1:2];
                sel   <= wb_sel_i;
                we    <= wb_we_i;
                wdata <= wb_dat_i;
            end else if (state == ACCESS) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Next-state selection; dropping cyc during ACCESS abandons the word.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS: begin
                if (!wb_cyc_i)       state_next = IDLE;
                else if (idx == 2'd3) state_next = ACK;
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side strobes, address and write byte, decoded from state.
    always_comb begin
        mem_adr   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_dat_o = '0;
        if (state == ACCESS) begin
            mem_adr = {base, idx};
            mem_en  = sel[lane] && wb_cyc_i;
            mem_we  = we && sel[lane] && wb_cyc_i;
            if (mem_we) mem_dat_o = wdata[{lane, 3'b000} +: 8];
        end
    end

    // Registered acknowledge and read-data assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= (state == ACCESS) && wb_cyc_i && (idx == 2'd3);
            if (accept) begin
                wb_dat_o <= '0;
            end else if ((state == ACCESS) && mem_en && !we) begin
                wb_dat_o[{lane, 3'b000} +: 8] <= mem_dat_i;
            end
        end
    end

endmodule
